// File: rtl/load_store_seq.sv
// load_store_seq: sequences stage-3 loads and stores onto the shared data-memory port.
// It also formats load results and flags misaligned accesses and memory timeouts.
module load_store_seq #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op_ld_sel,
    input  logic        op_is_store,
    input  logic [1:0]  op_st_size,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, FAULT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  tmo_cnt;
    logic        is_store_q;
    logic [2:0]  ld_sel_q;
    logic [1:0]  lane_q;
    logic        mem_req_q;
    logic        ld_valid_q;
    logic        fault_q;

    logic        mem_op;
    logic        misaligned;
    logic        tmo_hit;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_fmt;

    assign mem_op  = op_valid & (op_is_store | (op_ld_sel != 3'b111));
    assign tmo_hit = (tmo_cnt == CNT_LAST);

    always_comb begin
        misaligned = 1'b0;
        if (op_is_store) begin
            case (op_st_size)
                2'b00:   misaligned = 1'b0;
                2'b01:   misaligned = op_addr[0];
                default: misaligned = |op_addr[1:0];
            endcase
        end else begin
            case (op_ld_sel)
                3'b000, 3'b011: misaligned = 1'b0;
                3'b001, 3'b100: misaligned = op_addr[0];
                default:        misaligned = |op_addr[1:0];
            endcase
        end
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = op_wdata;
        case (op_st_size)
            2'b00: begin
                st_be    = 4'b0001 << op_addr[1:0];
                st_wdata = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = op_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{op_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = op_wdata;
            end
        endcase
    end

    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (lane_q)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_sel_q)
            3'b000:  ld_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_fmt = {{16{rd_half[15]}}, rd_half};
            3'b011:  ld_fmt = {24'b0, rd_byte};
            3'b100:  ld_fmt = {16'b0, rd_half};
            default: ld_fmt = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            is_store_q  <= 1'b0;
            ld_sel_q    <= 3'b111;
            lane_q      <= '0;
            mem_req_q   <= 1'b0;
            ld_valid_q  <= 1'b0;
            fault_q     <= 1'b0;
            ld_data     <= '0;
            fault_cause <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
        end else begin
            ld_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_op) begin
                        tmo_cnt    <= '0;
                        is_store_q <= op_is_store;
                        ld_sel_q   <= op_ld_sel;
                        lane_q     <= op_addr[1:0];
                        mem_we     <= op_is_store;
                        mem_addr   <= {op_addr[31:2], 2'b00};
                        mem_be     <= op_is_store ? st_be : 4'b0000;
                        mem_wdata  <= st_wdata;
                        if (misaligned) begin
                            state       <= FAULT;
                            fault_q     <= 1'b1;
                            fault_cause <= 2'b01;
                        end else begin
                            state     <= REQ;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                // A store grant completes the access, so it beats a same-cycle timeout;
                // a load grant only moves to WAIT and loses to it.
                REQ: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (mem_gnt && is_store_q) begin
                        state     <= RESP;
                        mem_req_q <= 1'b0;
                    end else if (tmo_hit) begin
                        state       <= FAULT;
                        mem_req_q   <= 1'b0;
                        fault_q     <= 1'b1;
                        fault_cause <= 2'b10;
                    end else if (mem_gnt) begin
                        state     <= WAIT;
                        mem_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (mem_rvalid) begin
                        state      <= RESP;
                        ld_data    <= ld_fmt;
                        ld_valid_q <= 1'b1;
                    end else if (tmo_hit) begin
                        state       <= FAULT;
                        fault_q     <= 1'b1;
                        fault_cause <= 2'b10;
                    end
                end
                RESP:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs are forced low for as long as reset is held.
    assign mem_req  = mem_req_q & rst_n;
    assign ld_valid = ld_valid_q & rst_n;
    assign fault    = fault_q & rst_n;
    assign stall    = rst_n & (((state == IDLE) & mem_op) | (state == REQ) | (state == WAIT));

endmodule

// File: tb/tb_load_store_seq.sv
// Randomized scoreboard bench for load_store_seq: the driver pushes expected events with
// their expected cycle, and a monitor pops and compares whatever the DUT presents.
module tb_load_store_seq;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_ld_sel = 3'b111;
    logic        op_is_store = 1'b0;
    logic [1:0]  op_st_size = 2'b00;
    logic [31:0] op_addr = '0;
    logic [31:0] op_wdata = '0;
    logic        stall, ld_valid, fault, mem_req, mem_we;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [1:0]  fault_cause;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    load_store_seq #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ld_sel(op_ld_sel),
        .op_is_store(op_is_store), .op_st_size(op_st_size), .op_addr(op_addr),
        .op_wdata(op_wdata), .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
        .fault(fault), .fault_cause(fault_cause), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // kind: 0 load result, 1 fault, 2 store request granted, 3 load request granted
    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  be;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] be);
        ev_t e;
        e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.be = be;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] be);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d a=%h b=%h be=%b at cycle %0d, expected none",
                     kind, a, b, be, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || e.a !== a || e.b !== b || e.be !== be) begin
            errors++;
            $display("FAIL event: got kind=%0d cyc=%0d a=%h b=%h be=%b, expected kind=%0d cyc=%0d a=%h b=%h be=%b",
                     kind, cyc, a, b, be, e.kind, e.cyc, e.a, e.b, e.be);
        end
    endtask

    // ---- reference model, stated in terms of access width and byte arithmetic ----
    function automatic int acc_bytes(input logic st, input logic [2:0] sel, input logic [1:0] sz);
        if (st) return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sel == 3'd0 || sel == 3'd3) return 1;
        if (sel == 3'd1 || sel == 3'd4) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] sel, input logic [31:0] w,
                                             input logic [31:0] addr);
        logic [31:0] v;
        int          lane;
        lane = int'(addr % 4);
        case (sel)
            3'd0, 3'd3: begin
                v = (w >> (8 * lane)) & 32'hFF;
                if (sel == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd4: begin
                v = (w >> (8 * (lane / 2) * 2)) & 32'hFFFF;
                if (sel == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic exp_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [3:0] be, output logic [31:0] data);
        int lane;
        lane = int'(addr % 4);
        if (sz == 2'd0) begin
            be = 4'(1 << lane);
            data = (wd & 32'hFF) * 32'h0101_0101;
        end else if (sz == 2'd1) begin
            be = 4'(3 << ((lane / 2) * 2));
            data = (wd & 32'hFFFF) * 32'h0001_0001;
        end else begin
            be = 4'hF;
            data = wd;
        end
    endtask

    // ---- driver: one memory op, with grant after gd REQ cycles and rvalid rd WAIT cycles later ----
    task automatic do_op(input logic st, input logic [2:0] sel, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd, input int gd,
                         input int rd, input logic [31:0] rdat, input logic spur);
        int          t0, len, req_end, gnt_k, rv_k;
        logic        mis;
        logic [3:0]  sbe;
        logic [31:0] swd;
        @(negedge clk);
        op_valid = 1'b1; op_is_store = st; op_ld_sel = sel; op_st_size = sz;
        op_addr = addr; op_wdata = wd;
        t0 = cyc;
        mis = (addr % acc_bytes(st, sel, sz)) != 0;
        gnt_k = -1; rv_k = -1;
        if (mis) begin
            len = 1; req_end = 0;
            push(1, t0 + 1, 32'd1, '0, '0);
        end else if (st) begin
            exp_store(sz, addr, wd, sbe, swd);
            if (gd + 1 <= TMO) begin
                gnt_k = 1 + gd; len = 2 + gd; req_end = gnt_k;
                push(2, t0 + gnt_k, addr & ~32'd3, swd, sbe);
            end else begin
                len = TMO + 1; req_end = TMO;
                push(1, t0 + TMO + 1, 32'd2, '0, '0);
            end
        end else begin
            if (gd + rd + 2 <= TMO) begin
                gnt_k = 1 + gd; rv_k = 2 + gd + rd; len = 3 + gd + rd; req_end = gnt_k;
                push(3, t0 + gnt_k, addr & ~32'd3, '0, '0);
                push(0, t0 + len, exp_load(sel, rdat, addr), '0, '0);
            end else if (gd + 1 < TMO) begin
                gnt_k = 1 + gd; len = TMO + 1; req_end = gnt_k;
                push(3, t0 + gnt_k, addr & ~32'd3, '0, '0);
                push(1, t0 + TMO + 1, 32'd2, '0, '0);
            end else begin
                len = TMO + 1; req_end = TMO;
                push(1, t0 + TMO + 1, 32'd2, '0, '0);
            end
        end
        for (int k = 0; k <= len; k++) begin
            if (k > 0) @(negedge clk);
            // a misaligned op gets a permanent grant so that any stray request is caught
            mem_gnt    = (k == gnt_k) || mis;
            mem_rvalid = (k == rv_k) || (spur && !mis && k == 1 && gnt_k != 1);
            mem_rdata  = (k == rv_k) ? rdat : $urandom;
            #1;
            check("stall", 32'(stall), 32'(k < len));
            check("mem_req", 32'(mem_req), 32'(k >= 1 && k <= req_end));
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic gap(input logic nonmem, input logic rv);
        @(negedge clk);
        op_valid    = nonmem | 1'($urandom_range(0, 1));
        op_is_store = 1'b0;
        op_ld_sel   = 3'b111;
        mem_gnt     = 1'b0;
        mem_rvalid  = rv;
        mem_rdata   = $urandom;
        #1;
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_mem_req", 32'(mem_req), 32'd0);
    endtask

    // ---- monitor ----
    initial begin
        logic        pv_req, pv_gnt, pv_we;
        logic [31:0] pv_addr, pv_wd;
        logic [3:0]  pv_be;
        pv_req = 1'b0; pv_gnt = 1'b0; pv_we = 1'b0;
        pv_addr = '0; pv_wd = '0; pv_be = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (mem_req && pv_req && !pv_gnt)
                    check("req_stable", {mem_addr[31:2], mem_we, 1'b0} ^ {mem_wdata[3:0], mem_be, 24'd0},
                          {pv_addr[31:2], pv_we, 1'b0} ^ {pv_wd[3:0], pv_be, 24'd0});
                if (mem_req && pv_req && !pv_gnt)
                    check("req_stable_wdata", mem_wdata, pv_wd);
                if (ld_valid) got(0, ld_data, '0, '0);
                if (fault) got(1, 32'(fault_cause), '0, '0);
                if (mem_req && mem_gnt) begin
                    if (mem_we) got(2, mem_addr, mem_wdata, mem_be);
                    else        got(3, mem_addr, '0, mem_be);
                end
            end
            pv_req = mem_req && rst_n; pv_gnt = mem_gnt; pv_we = mem_we;
            pv_addr = mem_addr; pv_wd = mem_wdata; pv_be = mem_be;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_fault_cause", 32'(fault_cause), 32'd0);
        rst_n = 1'b1;

        do_op(1'b0, 3'b000, 2'b00, 32'h0000_1003, '0, 0, 0, 32'h80FF_1234, 1'b0);
        check("lb_sign", ld_data, 32'hFFFF_FF80);
        do_op(1'b0, 3'b100, 2'b00, 32'h0000_2002, '0, 0, 0, 32'h8001_7FFF, 1'b0);
        check("lhu_upper", ld_data, 32'h0000_8001);
        do_op(1'b1, 3'b111, 2'b01, 32'h0000_3002, 32'h1234_ABCD, 4, 0, '0, 1'b1);
        do_op(1'b0, 3'b010, 2'b00, 32'h0000_4001, '0, 0, 0, '0, 1'b0);
        check("misaligned_cause", 32'(fault_cause), 32'd1);
        do_op(1'b0, 3'b001, 2'b00, 32'h0000_7002, '0, 3, 3, 32'hFEDC_8765, 1'b1);
        do_op(1'b1, 3'b111, 2'b00, 32'h0000_7001, 32'h0000_0055, 7, 0, '0, 1'b0);
        do_op(1'b1, 3'b111, 2'b10, 32'h0000_7004, 32'hCAFE_F00D, 8, 0, '0, 1'b0);
        do_op(1'b0, 3'b011, 2'b00, 32'h0000_1001, '0, 1, 2, 32'h0000_F000, 1'b0);

        // timeout with no grant, then a late rvalid three cycles after the fault
        do_op(1'b0, 3'b010, 2'b00, 32'h0000_6000, '0, 99, 0, '0, 1'b0);
        check("timeout_cause", 32'(fault_cause), 32'd2);
        gap(1'b0, 1'b0);
        gap(1'b0, 1'b0);
        gap(1'b0, 1'b1);
        gap(1'b0, 1'b0);

        // reset while a load waits for its response
        @(negedge clk);
        op_valid = 1'b1; op_is_store = 1'b0; op_ld_sel = 3'b010; op_addr = 32'h0000_5008;
        t0 = cyc;
        push(3, t0 + 1, 32'h0000_5008, '0, '0);
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_ld_valid", 32'(ld_valid), 32'd0);
        check("midrst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check("midrst_ld_data", ld_data, 32'd0);
        check("midrst_fault_cause", 32'(fault_cause), 32'd0);
        rst_n = 1'b1;
        gap(1'b0, 1'b1);
        gap(1'b0, 1'b0);
        do_op(1'b0, 3'b010, 2'b00, 32'h0000_5000, '0, 0, 0, 32'h1357_9BDF, 1'b0);
        check("after_rst_lw", ld_data, 32'h1357_9BDF);

        for (int i = 0; i < 300; i++) begin
            logic        st;
            logic [2:0]  sel;
            logic [1:0]  sz;
            logic [31:0] addr;
            int          gd, rd, nb;
            repeat ($urandom_range(0, 2)) gap(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            st   = ($urandom_range(0, 2) == 0);
            sel  = 3'($urandom_range(0, 4));
            sz   = 2'($urandom_range(0, 3));
            addr = $urandom;
            nb   = acc_bytes(st, sel, sz);
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(nb) - 32'd1);
            gd = ($urandom_range(0, 11) == 0) ? 99 : int'($urandom_range(0, 3));
            rd = ($urandom_range(0, 11) == 0) ? 99 : int'($urandom_range(0, 3));
            do_op(st, sel, sz, addr, $urandom, gd, rd, $urandom, $urandom_range(0, 3) == 0);
        end

        repeat (4) gap(1'b0, 1'b0);
        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_seq.md
# load_store_seq

Sequences every stage-3 memory instruction onto the shared data-memory port through a request/grant/response handshake. It stalls the pipeline while the access is outstanding. For loads, it returns the formatted result: byte/half lane selection plus sign or zero extension, using the 3-bit load-select code produced by the stage-3 load decoder. It also generates store byte enables and lane-replicated write data, and reports misaligned accesses and memory timeouts.

## Interface
- TIMEOUT, 255: max cycles an access may spend in REQ+WAIT before a timeout fault (legal range 2..255).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- op_valid  in  1  a stage-3 instruction is present.
- op_ld_sel  in  3  load code: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 111 not a load.
- op_is_store  in  1  store instruction; when 1, op_ld_sel is ignored.
- op_st_size  in  2  store size: 00 byte, 01 half, 10 word (11 treated as word).
- op_addr  in  32  effective byte address.
- op_wdata  in  32  store data, right-aligned.
- stall  out  1  holds the pipeline (combinational).
- ld_valid  out  1  one-cycle pulse; ld_data valid.
- ld_data  out  32  formatted load result, held until next ld_valid.
- fault  out  1  one-cycle pulse.
- fault_cause  out  2  01 misaligned, 10 timeout; held until next fault.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  {op_addr[31:2], 2'b00}.
- mem_be  out  4  byte enables (all zero for loads).
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

## Operation
- **States:** IDLE, REQ, WAIT, RESP, FAULT.
- **Accept rule:**
  - An op is a memory op when op_valid=1 and (op_is_store=1 or op_ld_sel≠111).
  - IDLE with a memory op → capture addr, size/code, wdata and store flag into registers; clear the timeout counter.
  - If misaligned (half with addr[0]=1; word with addr[1:0]≠00) → FAULT with cause 01; no memory request is issued.
  - Otherwise → REQ.
- **REQ:**
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata are driven from registers and remain stable until grant.
  - On mem_gnt: a store → RESP; a load → WAIT.
- **WAIT:** mem_req=0. On mem_rvalid → latch formatted data, then RESP. mem_rvalid in REQ or IDLE is ignored.
- **RESP:**
  - ld_valid=1 for loads only; stall=0.
  - Always → IDLE.
  - No accept occurs in RESP; the pipeline advances at the end of this cycle.
- **FAULT:** fault=1, stall=0, then → IDLE.
- **Timeout:**
  - The counter increments each cycle spent in REQ or WAIT.
  - After TIMEOUT such cycles without completion → FAULT with cause 10; mem_req drops.
  - A late mem_rvalid after a timeout is ignored.
- **stall** = (IDLE and accept) or REQ or WAIT.
- **Load format (lane = addr[1:0]):**
  - LB/LBU: byte lane, sign/zero extended to 32 bits.
  - LH/LHU: half lane addr[1], sign/zero extended.
  - LW: full word.
- **Store format:**
  - Byte: be = 0001<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: be = 0011<<(2·addr[1]); wdata = {2{wdata[15:0]}}.
  - Word: be = 1111.
- **Reset:**
  - rst_n low at an edge → IDLE, counter 0; ld_data and fault_cause are cleared.
  - Outputs are 0 while in reset: mem_req, ld_valid, fault and stall.
  - A reset mid-access abandons the access; a response arriving afterwards is ignored.

## Timing
- **Load, zero-wait memory:** accept cycle T (stall=1); REQ at T+1 (grant in the same cycle); WAIT at T+2 (rvalid); RESP at T+3 with ld_valid=1 and stall=0. Minimum load latency is 3 cycles.
- **Store, grant at T+1:** RESP at T+2. Minimum store latency is 2 cycles.
- **Misaligned op:** accepted at T; FAULT at T+1.
- **Back-to-back ops:** the earliest next accept is the cycle after RESP or FAULT.
- **Timeout:** with TIMEOUT=N, REQ/WAIT occupy at most N cycles, and FAULT is entered on the next edge after them.

## Test plan
- **LB, sign extension:** LB at addr 0x1003, rdata 0x80FF_1234, gnt and rvalid at first opportunity → ld_data=0xFFFF_FF80, ld_valid at T+3, stall high T..T+2.
- **LHU, upper half:** LHU at 0x2002, rdata 0x8001_7FFF → ld_data=0x0000_8001.
- **Store half, delayed grant:** SH at 0x3002, wdata 0xABCD, gnt held off 4 cycles → mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x3000, all stable until grant; RESP at grant+1; no ld_valid.
- **Misaligned word load:** LW at 0x4001 → fault=1, cause=01 at T+1; mem_req never asserted.
- **Timeout:** TIMEOUT=8, no gnt → mem_req high T+1..T+8, fault cause 10 at T+9; an rvalid injected at T+12 produces no ld_valid.
- **Reset mid-access:** rst_n low during WAIT → IDLE next edge, all outputs 0; later rvalid ignored; a new LW at 0x5000 completes normally.
